// File: rtl/bcd_conv_arbiter_if.sv
// Request/result bundle shared by the BCD conversion arbiter and its requesters.
interface bcd_conv_arbiter_if #(
    parameter int NUM_REQ = 4
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]   req;
    logic [NUM_REQ*8-1:0] bin_in;
    logic [NUM_REQ-1:0]   gnt;
    logic                 busy;
    logic                 done;
    logic [ID_W-1:0]      done_id;
    logic [3:0]           hundreds;
    logic [3:0]           tens;
    logic [3:0]           ones;

    modport master (
        output req, bin_in,
        input  gnt, busy, done, done_id, hundreds, tens, ones
    );

    modport slave (
        input  req, bin_in,
        output gnt, busy, done, done_id, hundreds, tens, ones
    );
endinterface

// File: rtl/bcd_conv_arbiter.sv
// Shared shift-add-3 binary-to-BCD engine with round-robin arbitration among NUM_REQ sources.
// Define BCD_ARB_FIXED_PRIORITY_EN to switch to fixed lowest-index-wins priority.
//
// state | meaning
// IDLE  | arbitrate; grant and capture the winner's operand in the same cycle
// SHIFT | eight add-3/shift iterations, one per cycle
// DONE  | result presented on the digit outputs, done pulse high
module bcd_conv_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic             clk,
    input  logic             reset,
    bcd_conv_arbiter_if.slave bus
);
    localparam int ID_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [7:0]        bin_q;
    logic [11:0]       bcd_q;
    logic [2:0]        cnt;
    logic [ID_W-1:0]   id_q;
    logic [3:0]        hundreds_q;
    logic [3:0]        tens_q;
    logic [3:0]        ones_q;
    logic [ID_W-1:0]   done_id_q;
    logic [ID_W-1:0]   winner;
    logic              found;
    logic              capture;
    logic [NUM_REQ-1:0] gnt_c;
    logic              busy_c;
    logic              done_c;
    logic [11:0]       bcd_adj;
    logic [19:0]       shifted;
`ifndef BCD_ARB_FIXED_PRIORITY_EN
    logic [ID_W-1:0]   last_q;
    logic [ID_W-1:0]   idx;
`endif

    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    always_comb begin
        winner = '0;
        found  = 1'b0;
`ifdef BCD_ARB_FIXED_PRIORITY_EN
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && bus.req[ID_W'(i)]) begin
                winner = ID_W'(i);
                found  = 1'b1;
            end
        end
`else
        idx = '0;
        // search starts just after the previous winner and wraps
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = ID_W'((int'(last_q) + k) % NUM_REQ);
            if (!found && bus.req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
`endif
    end

    always_comb begin
        state_nxt = state;
        gnt_c     = '0;
        busy_c    = 1'b0;
        done_c    = 1'b0;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (found && !reset) begin
                    gnt_c[winner] = 1'b1;
                    capture       = 1'b1;
                    state_nxt     = SHIFT;
                end
            end
            SHIFT: begin
                busy_c = 1'b1;
                if (cnt == 3'd7) state_nxt = DONE;
            end
            DONE: begin
                busy_c    = 1'b1;
                done_c    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    assign bcd_adj = {add3(bcd_q[11:8]), add3(bcd_q[7:4]), add3(bcd_q[3:0])};
    assign shifted = {bcd_adj, bin_q} << 1;

    // digits are loaded on the last iteration so they are already valid during DONE
    always_ff @(posedge clk) begin
        if (reset) begin
            bin_q      <= '0;
            bcd_q      <= '0;
            cnt        <= '0;
            id_q       <= '0;
            hundreds_q <= '0;
            tens_q     <= '0;
            ones_q     <= '0;
            done_id_q  <= '0;
`ifndef BCD_ARB_FIXED_PRIORITY_EN
            last_q     <= ID_W'(NUM_REQ - 1);
`endif
        end else begin
            if (capture) begin
                bin_q  <= bus.bin_in[{winner, 3'b000} +: 8];
                bcd_q  <= '0;
                cnt    <= '0;
                id_q   <= winner;
`ifndef BCD_ARB_FIXED_PRIORITY_EN
                last_q <= winner;
`endif
            end else if (state == SHIFT) begin
                bcd_q <= shifted[19:8];
                bin_q <= shifted[7:0];
                cnt   <= cnt + 3'd1;
                if (cnt == 3'd7) begin
                    hundreds_q <= shifted[19:16];
                    tens_q     <= shifted[15:12];
                    ones_q     <= shifted[11:8];
                    done_id_q  <= id_q;
                end
            end
        end
    end

    assign bus.gnt      = gnt_c;
    assign bus.busy     = busy_c;
    assign bus.done     = done_c;
    assign bus.done_id  = done_id_q;
    assign bus.hundreds = hundreds_q;
    assign bus.tens     = tens_q;
    assign bus.ones     = ones_q;
endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Bench for bcd_conv_arbiter: cycle model built from decimal arithmetic plus directed literal checks.
module tb_bcd_conv_arbiter;
    localparam int N = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    bcd_conv_arbiter_if #(.NUM_REQ(N)) bus ();
    bcd_conv_arbiter #(.NUM_REQ(N)) dut (.clk(clk), .reset(reset), .bus(bus));

    int checks = 0;
    int errors = 0;

    // model state: phase counts cycles since grant (-1 when no conversion in flight)
    int m_phase = -1;
    int m_last  = N - 1;
    int m_val   = 0;
    int m_id    = 0;
    int e_h = 0, e_t = 0, e_o = 0, e_id = 0;

    int cyc = 0;
    int gnt_cyc = 0;
    int done_cyc = 0;
    int done_count = 0;
    logic [N-1:0] gnt_seen = '0;
    int gq[$];
    int dq[$];
    int dcyc[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting (cycle %0d)", name, cyc);
    endtask

    function automatic int pick(input logic [N-1:0] r, input int last);
`ifdef BCD_ARB_FIXED_PRIORITY_EN
        for (int i = 0; i < N; i++) if (r[i]) return i;
`else
        for (int k = 1; k <= N; k++) if (r[(last + k) % N]) return (last + k) % N;
`endif
        return -1;
    endfunction

    always @(negedge clk) begin : mon
        logic [N-1:0] e_gnt;
        int w;
        cyc++;
        e_gnt = '0;
        w = -1;
        if (m_phase < 0 && !reset && |bus.req) begin
            w = pick(bus.req, m_last);
            e_gnt[w] = 1'b1;
        end
        chk("gnt", bus.gnt, e_gnt);
        chk("busy", bus.busy, m_phase >= 1);
        chk("done", bus.done, m_phase == 9);
        chk("hundreds", bus.hundreds, e_h);
        chk("tens", bus.tens, e_t);
        chk("ones", bus.ones, e_o);
        chk("done_id", bus.done_id, e_id);

        gnt_seen = bus.gnt;
        if (bus.gnt != '0) begin
            gnt_cyc = cyc;
            for (int i = 0; i < N; i++) if (bus.gnt[i]) gq.push_back(i);
        end
        if (bus.done) begin
            done_count++;
            done_cyc = cyc;
            dq.push_back(int'(bus.done_id));
            dcyc.push_back(cyc);
        end

        if (reset) begin
            m_phase = -1;
            m_last  = N - 1;
            e_h = 0; e_t = 0; e_o = 0; e_id = 0;
        end else if (w >= 0) begin
            m_phase = 1;
            m_val   = int'(bus.bin_in[8*w +: 8]);
            m_id    = w;
            m_last  = w;
        end else if (m_phase >= 1) begin
            if (m_phase == 8) begin
                e_h  = m_val / 100;
                e_t  = (m_val / 10) % 10;
                e_o  = m_val % 10;
                e_id = m_id;
            end
            m_phase = (m_phase == 9) ? -1 : m_phase + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_gnt(input string name);
        int n = 0;
        do begin
            tick();
            n++;
        end while (gnt_seen == '0 && n < 20);
        if (gnt_seen == '0) timeout(name);
    endtask

    task automatic wait_done(input string name);
        int start = done_count;
        int n = 0;
        while (done_count == start && n < 30) begin
            tick();
            n++;
        end
        if (done_count == start) timeout(name);
    endtask

    task automatic convert(input int idx, input int val, input int h, input int t, input int o);
        bus.bin_in[8*idx +: 8] = 8'(val);
        bus.req[idx] = 1'b1;
        wait_gnt("conv_gnt");
        chk("conv_gnt_idx", gnt_seen, 1 << idx);
        bus.req[idx] = 1'b0;
        wait_done("conv_done");
        chk("lit_hundreds", bus.hundreds, h);
        chk("lit_tens", bus.tens, t);
        chk("lit_ones", bus.ones, o);
        chk("lit_done_id", bus.done_id, idx);
        chk("latency", done_cyc - gnt_cyc, 9);
    endtask

    initial begin
        int start;
        int n;
        bus.req    = '0;
        bus.bin_in = '0;
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_gnt", bus.gnt, 0);
        chk("rst_digits", {bus.hundreds, bus.tens, bus.ones}, 0);
        tick();

        convert(0, 47, 0, 4, 7);
        convert(1, 209, 2, 0, 9);
        convert(2, 0, 0, 0, 0);
        convert(3, 255, 2, 5, 5);

        // operand stability: operand changes right after capture
        bus.bin_in[7:0] = 8'd47;
        bus.req[0] = 1'b1;
        wait_gnt("stab_gnt");
        bus.bin_in[7:0] = 8'd200;
        bus.req[0] = 1'b0;
        wait_done("stab_done");
        chk("stab_digits", {bus.hundreds, bus.tens, bus.ones}, 12'h047);

        convert(1, 100, 1, 0, 0);
        convert(3, 99, 0, 9, 9);

        // contention: all requesters, each drops after its grant
        bus.bin_in = {8'd255, 8'd156, 8'd34, 8'd12};
        gq.delete(); dq.delete(); dcyc.delete();
        start = done_count;
        bus.req = '1;
        n = 0;
        while (done_count - start < 4 && n < 80) begin
            tick();
            bus.req = bus.req & ~gnt_seen;
            n++;
        end
        if (done_count - start < 4) timeout("contention");
        chk("cont_gnt_count", gq.size(), 4);
        chk("cont_done_count", dq.size(), 4);
        for (int i = 0; i < 4 && i < gq.size() && i < dq.size(); i++) begin
            chk("cont_gnt_order", gq[i], i);
            chk("cont_done_order", dq[i], i);
        end
        for (int i = 1; i < dcyc.size(); i++) chk("cont_spacing", dcyc[i] - dcyc[i-1], 10);
        chk("cont_last_digits", {bus.hundreds, bus.tens, bus.ones}, 12'h255);

`ifdef BCD_ARB_FIXED_PRIORITY_EN
        gq.delete();
        start = done_count;
        bus.req = '1;
        n = 0;
        while (done_count - start < 2 && n < 40) begin
            tick();
            n++;
        end
        bus.req = '0;
        wait_done("fixed_drain");
        if (gq.size() == 0) timeout("fixed_gnt");
        foreach (gq[i]) chk("fixed_gnt_idx", gq[i], 0);
`endif

        // reset four cycles after grant aborts the conversion
        bus.bin_in[7:0] = 8'd47;
        bus.req[0] = 1'b1;
        wait_gnt("abort_gnt");
        bus.req = '0;
        repeat (3) tick();
        start = done_count;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_busy", bus.busy, 0);
        chk("abort_done", bus.done, 0);
        chk("abort_gnt", bus.gnt, 0);
        chk("abort_digits", {bus.hundreds, bus.tens, bus.ones}, 0);
        chk("abort_done_id", bus.done_id, 0);
        repeat (12) tick();
        chk("abort_no_done", done_count - start, 0);

        // pointer restarted: index 0 wins over index 1
        bus.bin_in[7:0]  = 8'd58;
        bus.bin_in[15:8] = 8'd77;
        bus.req = 4'b0011;
        wait_gnt("post_gnt0");
        chk("post_first_winner", gnt_seen, 4'b0001);
        bus.req[0] = 1'b0;
        wait_done("post_done0");
        chk("post_digits0", {bus.hundreds, bus.tens, bus.ones}, 12'h058);
        wait_gnt("post_gnt1");
        chk("post_second_winner", gnt_seen, 4'b0010);
        bus.req = '0;
        wait_done("post_done1");
        chk("post_digits1", {bus.hundreds, bus.tens, bus.ones}, 12'h077);
        chk("post_done_id1", bus.done_id, 1);

        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1);
    end
endmodule
